// File: rtl/inst_split_queue_pkg.sv
// inst_split_pkg: instruction field positions/widths and queue entry layout
package inst_split_pkg;
    localparam int OP_LSB    = 26;
    localparam int OP_WID    = 6;
    localparam int RS_LSB    = 21;
    localparam int RS_WID    = 5;
    localparam int RT_LSB    = 16;
    localparam int RT_WID    = 5;
    localparam int RD_LSB    = 11;
    localparam int RD_WID    = 5;
    localparam int SHAMT_LSB = 6;
    localparam int SHAMT_WID = 5;
    localparam int FUNCT_LSB = 0;
    localparam int FUNCT_WID = 6;
    localparam int IMM_LSB   = 0;
    localparam int IMM_WID   = 16;
    localparam int JADDR_LSB = 0;
    localparam int JADDR_WID = 26;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        sext;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/inst_split_queue_if.sv
// inst_split_queue_if: producer/consumer handshake and decoded head fields
interface inst_split_queue_if #(
    parameter int DEPTH = 4,
    parameter int IMM_W = 32
);
    import inst_split_pkg::*;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_inst;
    logic [31:0]              in_pc;
    logic                     in_sext;
    logic                     out_valid;
    logic                     out_ready;
    logic [OP_WID-1:0]        op;
    logic [RS_WID-1:0]        rs;
    logic [RT_WID-1:0]        rt;
    logic [RD_WID-1:0]        rd;
    logic [SHAMT_WID-1:0]     shamt;
    logic [FUNCT_WID-1:0]     funct;
    logic [IMM_WID-1:0]       imm16;
    logic [IMM_W-1:0]         imm_ext;
    logic [JADDR_WID-1:0]     j_addr;
    logic [31:0]              j_target;
    logic [31:0]              pc_plus4;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, in_valid, in_inst, in_pc, in_sext, out_ready,
        input  in_ready, out_valid, op, rs, rt, rd, shamt, funct, imm16,
               imm_ext, j_addr, j_target, pc_plus4, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, in_sext, out_ready,
        output in_ready, out_valid, op, rs, rt, rd, shamt, funct, imm16,
               imm_ext, j_addr, j_target, pc_plus4, count
    );
endinterface

// File: rtl/inst_split_queue_fifo.sv
// sync_fifo: power-of-2 depth FIFO storage with wrapping pointers and occupancy count
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    assign rdata = mem[rp];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

    // storage is never cleared; only occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    // pointers wrap naturally at the power-of-2 depth; reset and flush empty the queue
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/inst_split_queue.sv
// inst_split_queue: instruction queue that decodes fields of the head entry
module inst_split_queue
    import inst_split_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IMM_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_split_queue_if.slave  bus
);
    entry_t wr;
    entry_t head;
    entry_t h;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;

    assign wr            = '{inst: bus.in_inst, pc: bus.in_pc, sext: bus.in_sext};
    assign bus.in_ready  = !full && rst_n;
    assign bus.out_valid = !empty;
    assign push          = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop           = bus.out_valid && bus.out_ready && !bus.flush;

    sync_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr),
        .rdata (head),
        .count (bus.count),
        .full  (full),
        .empty (empty)
    );

    // blank the head when nothing is queued so every decoded field reads zero
    always_comb begin
        h = empty ? '0 : head;
    end

    assign bus.op       = h.inst[OP_LSB +: OP_WID];
    assign bus.rs       = h.inst[RS_LSB +: RS_WID];
    assign bus.rt       = h.inst[RT_LSB +: RT_WID];
    assign bus.rd       = h.inst[RD_LSB +: RD_WID];
    assign bus.shamt    = h.inst[SHAMT_LSB +: SHAMT_WID];
    assign bus.funct    = h.inst[FUNCT_LSB +: FUNCT_WID];
    assign bus.imm16    = h.inst[IMM_LSB +: IMM_WID];
    assign bus.j_addr   = h.inst[JADDR_LSB +: JADDR_WID];
    assign bus.imm_ext  = {{(IMM_W-IMM_WID){h.sext & h.inst[IMM_LSB+IMM_WID-1]}}, h.inst[IMM_LSB +: IMM_WID]};
    assign bus.pc_plus4 = empty ? '0 : head.pc + 32'd4;
    assign bus.j_target = {bus.pc_plus4[31:28], bus.j_addr, 2'b00};
endmodule

// File: doc/inst_split_queue.md
INST_SPLIT_QUEUE -- requirements
Module: inst_split_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of 2, >=2).
REQ-002 SHALL have parameter IMM_W, default 32, meaning extended-immediate width (>=16).
REQ-003 SHALL have ports (one per line):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  discard all queued entries.
- in_valid  in  1  producer offers an instruction.
- in_ready  out  1  queue can accept.
- in_inst  in  32  raw instruction word.
- in_pc  in  32  PC of in_inst.
- in_sext  in  1  1 = sign-extend imm, 0 = zero-extend; captured per entry.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer takes head.
- op  out  6  head inst[31:26].
- rs  out  5  head inst[25:21].
- rt  out  5  head inst[20:16].
- rd  out  5  head inst[15:11].
- shamt  out  5  head inst[10:6].
- funct  out  6  head inst[5:0].
- imm16  out  16  head inst[15:0].
- imm_ext  out  IMM_W  imm16 extended per the entry's captured in_sext.
- j_addr  out  26  head inst[25:0].
- j_target  out  32  {pc_plus4[31:28], j_addr, 2'b00}.
- pc_plus4  out  32  head PC + 4, modulo 2^32.
- count  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-004 SHALL accept (push) an entry on a rising edge when in_valid && in_ready && !flush.
REQ-005 SHALL release (pop) the head on a rising edge when out_valid && out_ready && !flush.
REQ-006 in_ready SHALL equal (count != DEPTH) && rst_n; no pass-through when full, even with a simultaneous pop.
REQ-007 out_valid SHALL equal (count != 0); no bypass when empty: entry pushed at edge N is visible on outputs from cycle N+1.
REQ-008 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-009 Read/write pointers SHALL wrap modulo DEPTH without gaps.
REQ-010 All field outputs SHALL be combinational from the head entry while out_valid=1 and SHALL be all-zero while out_valid=0.
REQ-011 imm_ext SHALL be {(IMM_W-16){imm16[15]}, imm16} when the entry's sext=1, else zero-padded.
REQ-012 flush SHALL, at the next edge, set count=0 and both pointers to 0, overriding any push/pop in that cycle.
REQ-013 Handshake SHALL hold: producer keeps in_inst/in_pc/in_sext stable while in_valid && !in_ready; the block does not require this of out_ready.

Reset
REQ-014 While rst_n=0 at an edge, count, pointers SHALL reset to 0; queue storage need not be cleared.
REQ-015 During and after reset: out_valid=0, all field outputs 0, count=0; in_ready=0 while rst_n=0, 1 in the first cycle after release.
REQ-016 Reset asserted mid-operation SHALL discard all entries and override flush, push and pop.

Structure
REQ-017 A shared package inst_split_pkg SHALL hold field bit positions/widths (OP, RS, RT, RD, SHAMT, FUNCT, IMM, JADDR) and an entry struct {inst, pc, sext}.
REQ-018 Storage and pointers SHALL live in one sub-module sync_fifo (parametrised width/depth); field extraction, extension and j_target in the top.

Verification
REQ-019 Push 0x00221820 (pc 0x00400000) into empty queue -> next cycle out_valid=1, op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20, pc_plus4=0x00400004.
REQ-020 Push 0x2001FFFF with in_sext=1 then with in_sext=0 -> imm_ext=0xFFFFFFFF then 0x0000FFFF (IMM_W=32), order preserved.
REQ-021 Push 0x08100000 at pc 0x00400000 -> j_addr=0x0100000, j_target=0x00400000; 0x8C220004 -> op=0x23, rs=1, rt=2, imm16=0x0004.
REQ-022 out_ready=0, push 5 entries with DEPTH=4 -> count=4, in_ready=0, 5th not accepted; one pop+push while full -> only pop, count=3.
REQ-023 count=2, assert flush with in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, outputs zero; then wrap test: 10 push/pop pairs return inputs in order.
REQ-024 Assert rst_n=0 with count=3 -> next cycle count=0, out_valid=0, in_ready=0; after release in_ready=1.
